// File: rtl/wash_sequencer.sv
// wash_sequencer: program sequencer for the washing-machine controller.
// Steps FILL -> WASH -> RINSE (-> WASH -> RINSE on a double wash) -> SPIN
// on a coin, issuing a one-cycle start pulse plus a phase duration to the
// phase timer and waiting for the timer's done level before advancing.
//
// Ports:
//   clk                    system clock, posedge
//   rst                    synchronous reset, active-high
//   coin_in                coin accepted; starts a cycle from IDLE
//   double_wash            second wash+rinse request, latched with the coin
//   timer_pause            pause request, honoured only in SPIN
//   current_programm_done  timer done level
//   next_programm_started  one-cycle start pulse to the timer
//   value                  phase duration, held for the whole phase
//   state                  current phase (IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4)
//   busy                   high whenever state != IDLE
//   wash_done              one-cycle pulse when SPIN completes
module wash_sequencer #(
    parameter logic [31:0] FILL_TIME  = 32'd60,
    parameter logic [31:0] WASH_TIME  = 32'd300,
    parameter logic [31:0] RINSE_TIME = 32'd120,
    parameter logic [31:0] SPIN_TIME  = 32'd60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coin_in,
    input  logic        double_wash,
    input  logic        timer_pause,
    input  logic        current_programm_done,
    output logic        next_programm_started,
    output logic [31:0] value,
    output logic [2:0]  state,
    output logic        busy,
    output logic        wash_done
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ARM_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4
    } state_t;

    state_t           cur;
    logic [ARM_W-1:0] arm_cnt;     // cycles spent in the current phase, saturating
    logic             double_q;    // double-wash request latched with the coin
    logic             second_pass; // second WASH/RINSE pass already taken
    logic             armed;
    logic             phase_done;

    // The timer's done from the previous phase may still be high during the
    // entry cycle and the one after it, so done is only trusted from the
    // third cycle in a phase onward.
    assign armed      = arm_cnt[1];
    assign phase_done = armed && current_programm_done;

    assign state = STATE_W'(cur);

    // Sequencer state, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur                   <= IDLE;
            arm_cnt               <= '0;
            double_q              <= 1'b0;
            second_pass           <= 1'b0;
            next_programm_started <= 1'b0;
            value                 <= '0;
            busy                  <= 1'b0;
            wash_done             <= 1'b0;
        end else begin
            next_programm_started <= 1'b0;
            wash_done             <= 1'b0;
            if (arm_cnt != ARM_W'(3)) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end

            case (cur)
                IDLE: begin
                    if (coin_in) begin
                        cur                   <= FILL;
                        value                 <= FILL_TIME;
                        next_programm_started <= 1'b1;
                        busy                  <= 1'b1;
                        arm_cnt               <= '0;
                        double_q              <= double_wash;
                        second_pass           <= 1'b0;
                    end
                end
                FILL: begin
                    if (phase_done) begin
                        cur                   <= WASH;
                        value                 <= WASH_TIME;
                        next_programm_started <= 1'b1;
                        arm_cnt               <= '0;
                    end
                end
                WASH: begin
                    if (phase_done) begin
                        cur                   <= RINSE;
                        value                 <= RINSE_TIME;
                        next_programm_started <= 1'b1;
                        arm_cnt               <= '0;
                    end
                end
                RINSE: begin
                    if (phase_done) begin
                        next_programm_started <= 1'b1;
                        arm_cnt               <= '0;
                        if (double_q && !second_pass) begin
                            cur         <= WASH;
                            value       <= WASH_TIME;
                            second_pass <= 1'b1;
                        end else begin
                            cur   <= SPIN;
                            value <= SPIN_TIME;
                        end
                    end
                end
                SPIN: begin
                    // A pause holds SPIN even after the timer finishes.
                    if (phase_done && !timer_pause) begin
                        cur         <= IDLE;
                        value       <= '0;
                        busy        <= 1'b0;
                        wash_done   <= 1'b1;
                        double_q    <= 1'b0;
                        second_pass <= 1'b0;
                    end
                end
                default: begin
                    cur   <= IDLE;
                    value <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
Program sequencer for the washing-machine controller. It drives the phase timer: on a coin it steps through FILL, WASH, RINSE (with an optional second WASH/RINSE pass) and SPIN. For each phase it issues a one-cycle start pulse and a duration value to the timer, then waits for the timer's done level before advancing. It also handles the spin-pause request and reports end-of-cycle to the top level.

Parameters:
FILL_TIME, 32'd60, fill-phase duration in timer base units (timer applies ClkFreq scaling)
WASH_TIME, 32'd300, wash-phase duration
RINSE_TIME, 32'd120, rinse-phase duration
SPIN_TIME, 32'd60, spin-phase duration

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
coin_in  input  1  coin accepted; starts a cycle when in IDLE
double_wash  input  1  request a second wash+rinse pass; sampled only with an accepted coin
timer_pause  input  1  pause request; honoured only in SPIN
current_programm_done  input  1  timer done level
next_programm_started  output  1  one-cycle start pulse to the timer
value  output  32  phase duration to the timer; stable for the whole phase
state  output  3  current phase: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4
busy  output  1  high whenever state != IDLE
wash_done  output  1  one-cycle pulse when SPIN completes

Behaviour:
- All outputs are registered.
- Reset (rst=1 at posedge, any state, mid-phase included) gives: state=IDLE, next_programm_started=0, value=0, busy=0, wash_done=0, double latch=0, second-pass flag=0, arm counter cleared. Reset has priority over every other input.
- IDLE:
  - coin_in=1 at edge N -> at N+1: state=FILL, value=FILL_TIME, next_programm_started=1.
  - double_wash is latched at the same edge.
  - coin_in outside IDLE is ignored.
- Phase entry, every phase:
  - next_programm_started is high for exactly the first cycle in the phase.
  - value is updated in that same cycle and held until the next phase entry.
- Done masking:
  - current_programm_done is ignored in the entry cycle and the one cycle after it, because the timer's stale done may still be high.
  - It is sampled from the 3rd cycle in the phase onward.
- Transitions on sampled done=1 at edge M. The new state and pulse are visible at M+1.
  - FILL -> WASH (WASH_TIME).
  - WASH -> RINSE (RINSE_TIME).
  - RINSE -> WASH (WASH_TIME, second-pass flag set) if the double latch=1 and the second-pass flag=0. Otherwise RINSE -> SPIN (SPIN_TIME).
  - SPIN -> IDLE if timer_pause=0. At M+1: wash_done=1 for one cycle, value=0, busy=0, latches cleared.
  - SPIN with done=1 and timer_pause=1: stay in SPIN with no pulse. Exit on the first edge where done=1 and timer_pause=0.
- timer_pause has no effect outside SPIN.
- Done held high continuously across phases causes no extra advance within the mask window: minimum phase length is 3 cycles.
- wash_done and next_programm_started are never high in the same cycle. Coin acceptance occurs only in IDLE, so a coin on the same edge as wash_done is ignored.
- No arithmetic beyond the 2-bit saturating arm counter. value is passed through unmodified, 32 bits.

Test Plan:
- Normal cycle:
  - Stimulus: params 2/3/4/5; bench timer model asserts done 2 cycles after the arm window; coin at cycle 10, double_wash=0.
  - Response: states 1,2,3,4,0 in sequence; value 2,3,4,5 on each pulse; exactly 4 start pulses; one wash_done; busy falls with wash_done.
- Double wash:
  - Stimulus: coin with double_wash=1; double_wash dropped the next cycle.
  - Response: state sequence FILL,WASH,RINSE,WASH,RINSE,SPIN,IDLE; 6 start pulses; value=WASH_TIME on the 4th pulse.
- Stale done:
  - Stimulus: hold current_programm_done=1 from the coin onward.
  - Response: each phase lasts exactly 3 cycles; the pulse is never repeated inside a phase.
- Spin pause:
  - Stimulus: timer_pause=1 when SPIN done arrives; release 7 cycles later.
  - Response: state stays 4 for those 7 cycles; wash_done appears on the cycle after release; no extra start pulse.
- Reset mid-WASH:
  - Stimulus: assert rst for 1 cycle.
  - Response: next cycle state=0, value=0, busy=0. A new coin restarts at FILL with the double latch cleared.
- Ignored inputs:
  - Stimulus: coin_in pulsed during RINSE; timer_pause held during WASH.
  - Response: no state change and no extra pulses; the cycle completes normally.
